ddc_hb_decim_commutator: RTL and testbench

//   Input commutator for the x2 half-band decimators in the downconverter chain.
//   - Accepts a serial I/Q stream, one sample per i_valid.
//   - Groups the stream into consecutive sample pairs and issues one parallel output per pair.
//   - Output format is (newest, previous) with a single o_valid, matching the current/delay

---
 rtl/ddc_hb_pkg.sv | 17 +
 rtl/ddc_hb_gap_monitor.sv | 46 ++++
 rtl/ddc_hb_decim_commutator.sv | 91 +++++++++
 tb/tb_ddc_hb_decim_commutator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_hb_pkg.sv
// Shared types and helpers for the half-band decimator input commutator.
package ddc_hb_pkg;

  localparam int DDC_HB_WIDTH = 16;

  typedef enum logic {COMM_EMPTY, COMM_HALF} comm_state_t;

  typedef struct packed {
    logic signed [DDC_HB_WIDTH-1:0] inph;
    logic signed [DDC_HB_WIDTH-1:0] quad;
  } iq_sample_t;

  function automatic int gap_cnt_width(input int gap_limit);
    return $clog2(gap_limit + 1);
  endfunction

endpackage

// File: rtl/ddc_hb_gap_monitor.sv
// Pair-gap supervisor: times out a held phase-0 sample after GAP_LIMIT clocks in HALF.
// o_timeout is combinational off the count; o_gap_err is sticky until i_reset or i_sync.
module ddc_hb_gap_monitor
  import ddc_hb_pkg::*;
#(
  parameter int GAP_LIMIT = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_half,
  input  logic i_load,
  input  logic i_sync,
  output logic o_timeout,
  output logic o_gap_err
);

  localparam int CNT_W = gap_cnt_width(GAP_LIMIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GAP_LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_gap_err;

  // The GAP_LIMIT-th clock spent in HALF is the timeout clock.
  assign o_timeout = i_half && (r_cnt == LAST_CNT);
  assign o_gap_err = r_gap_err;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_gap_err <= 1'b0;
    end else begin
      if (i_sync || i_load || !i_half || o_timeout) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (i_sync) begin
        r_gap_err <= 1'b0;
      end else if (o_timeout) begin
        r_gap_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddc_hb_decim_commutator.sv
// Serial I/Q to (newest, previous) pair commutator for the x2 half-band; o_valid 1 clk after phase 1, no backpressure.
// Gap supervision is compiled in by DDC_HB_COMMUTATOR_GAP_MON_EN.
module ddc_hb_decim_commutator
  import ddc_hb_pkg::*;
#(
  parameter int WIDTH     = DDC_HB_WIDTH,
  parameter int GAP_LIMIT = 255
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph_data,
  input  logic signed [WIDTH-1:0] i_quad_data,
  input  logic                    i_valid,
  input  logic                    i_sync,
  output logic signed [WIDTH-1:0] o_inph_data,
  output logic signed [WIDTH-1:0] o_quad_data,
  output logic signed [WIDTH-1:0] o_inph_delay_data,
  output logic signed [WIDTH-1:0] o_quad_delay_data,
  output logic                    o_valid,
  output logic                    o_gap_err
);

  if (WIDTH != DDC_HB_WIDTH) begin : g_width_chk
    $error("WIDTH must match ddc_hb_pkg::DDC_HB_WIDTH");
  end
  if (GAP_LIMIT < 1) begin : g_limit_chk
    $error("GAP_LIMIT must be at least 1");
  end

  comm_state_t r_state;
  iq_sample_t  r_hold;
  iq_sample_t  r_out_new;
  iq_sample_t  r_out_dly;
  logic        r_valid;

  iq_sample_t  w_sample;
  logic        w_timeout;
  logic        w_capture;

  assign w_sample = '{inph: i_inph_data, quad: i_quad_data};

  // A sample starts a new pair on sync, from EMPTY, or when it lands on a timeout.
  assign w_capture = i_valid && (i_sync || (r_state == COMM_EMPTY) || w_timeout);

`ifdef DDC_HB_COMMUTATOR_GAP_MON_EN
  ddc_hb_gap_monitor #(
    .GAP_LIMIT (GAP_LIMIT)
  ) u_gap_mon (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_half    (r_state == COMM_HALF),
    .i_load    (w_capture),
    .i_sync    (i_sync),
    .o_timeout (w_timeout),
    .o_gap_err (o_gap_err)
  );
`else
  assign w_timeout = 1'b0;
  assign o_gap_err = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= COMM_EMPTY;
      r_hold    <= '0;
      r_out_new <= '0;
      r_out_dly <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_capture) begin
        r_hold  <= w_sample;
        r_state <= COMM_HALF;
      end else if (i_sync || w_timeout) begin
        r_state <= COMM_EMPTY;
      end else if (i_valid) begin
        r_out_new <= w_sample;
        r_out_dly <= r_hold;
        r_valid   <= 1'b1;
        r_state   <= COMM_EMPTY;
      end
    end
  end

  assign o_inph_data       = r_out_new.inph;
  assign o_quad_data       = r_out_new.quad;
  assign o_inph_delay_data = r_out_dly.inph;
  assign o_quad_delay_data = r_out_dly.quad;
  assign o_valid           = r_valid;

endmodule

// File: tb/tb_ddc_hb_decim_commutator.sv
// Bench for ddc_hb_decim_commutator: queue-based pairing model, per-cycle compare, directed pins.
module tb_ddc_hb_decim_commutator;

  localparam int W  = 16;
  localparam int GL = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] in_i = '0;
  logic signed [W-1:0] in_q = '0;
  logic                in_v = 1'b0;
  logic                in_s = 1'b0;
  logic signed [W-1:0] o_i, o_q, o_id, o_qd;
  logic                o_v, o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddc_hb_decim_commutator #(
    .WIDTH     (W),
    .GAP_LIMIT (GL)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_inph_data       (in_i),
    .i_quad_data       (in_q),
    .i_valid           (in_v),
    .i_sync            (in_s),
    .o_inph_data       (o_i),
    .o_quad_data       (o_q),
    .o_inph_delay_data (o_id),
    .o_quad_delay_data (o_qd),
    .o_valid           (o_v),
    .o_gap_err         (o_err)
  );

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: accepted samples queue up; two queued samples form one pair.
  logic signed [W-1:0] mq_i[$];
  logic signed [W-1:0] mq_q[$];
  int                  age = 0;
  bit                  tmo;
  logic signed [W-1:0] e_i = '0, e_q = '0, e_id = '0, e_qd = '0;
  logic                e_v = 1'b0, e_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_i.delete(); mq_q.delete();
      e_i = '0; e_q = '0; e_id = '0; e_qd = '0;
      e_v = 1'b0; e_err = 1'b0; age = 0;
    end else begin
      e_v = 1'b0;
      if (mq_i.size() == 1) age++;
`ifdef DDC_HB_COMMUTATOR_GAP_MON_EN
      tmo = (mq_i.size() == 1) && (age >= GL);
`else
      tmo = 1'b0;
`endif
      if (in_s) begin
        mq_i.delete(); mq_q.delete(); e_err = 1'b0;
      end else if (tmo) begin
        mq_i.delete(); mq_q.delete(); e_err = 1'b1;
      end
      if (in_v) begin
        mq_i.push_back(in_i); mq_q.push_back(in_q); age = 0;
        if (mq_i.size() == 2) begin
          e_id = mq_i[0]; e_i = mq_i[1];
          e_qd = mq_q[0]; e_q = mq_q[1];
          e_v  = 1'b1;
          mq_i.delete(); mq_q.delete();
        end
      end
    end
  end

  int d_i[$], d_id[$], d_q[$], d_qd[$];
  int m_i[$], m_id[$];

  always @(negedge clk) begin
    check("o_valid", o_v, e_v);
    check("o_inph", o_i, e_i);
    check("o_inph_dly", o_id, e_id);
    check("o_quad", o_q, e_q);
    check("o_quad_dly", o_qd, e_qd);
    check("o_gap_err", o_err, e_err);
    if (o_v === 1'b1) begin
      d_i.push_back(o_i); d_id.push_back(o_id);
      d_q.push_back(o_q); d_qd.push_back(o_qd);
    end
    if (e_v) begin
      m_i.push_back(e_i); m_id.push_back(e_id);
    end
  end

  task automatic clear_logs();
    d_i.delete(); d_id.delete(); d_q.delete(); d_qd.delete();
    m_i.delete(); m_id.delete();
  endtask

  task automatic drive(input bit v, input bit s, input int x);
    in_v = v; in_s = s;
    in_i = W'(x); in_q = W'(-x);
    @(posedge clk); #1;
  endtask

  task automatic chk_pair(input string nm, input int k, input int ei, input int ed);
    check({nm, "_present"}, d_i.size() > k, 1);
    check({nm, "_model_present"}, m_i.size() > k, 1);
    if (d_i.size() > k) begin
      check({nm, "_i"}, d_i[k], ei);
      check({nm, "_idly"}, d_id[k], ed);
      check({nm, "_q"}, d_q[k], -ei);
      check({nm, "_qdly"}, d_qd[k], -ed);
    end
    if (m_i.size() > k) begin
      check({nm, "_model_i"}, m_i[k], ei);
      check({nm, "_model_idly"}, m_id[k], ed);
    end
  endtask

  int pv;

  initial begin
    rst = 1'b1;
    #2;
    check("rst_valid", o_v, 0);
    check("rst_inph", o_i, 0);
    check("rst_inph_dly", o_id, 0);
    check("rst_quad", o_q, 0);
    check("rst_quad_dly", o_qd, 0);
    check("rst_gap_err", o_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    clear_logs();
    for (int k = 1; k <= 8; k++) drive(1, 0, k);
    drive(0, 0, 0); drive(0, 0, 0);
    check("cont_npairs", d_i.size(), 4);
    for (int k = 0; k < 4; k++) chk_pair("cont", k, 2 * k + 2, 2 * k + 1);

    clear_logs();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 10 * k); drive(0, 0, 0); drive(0, 0, 0);
    end
    check("sparse_npairs", d_i.size(), 2);
    chk_pair("sparse0", 0, 20, 10);
    chk_pair("sparse1", 1, 40, 30);

    clear_logs();
    drive(1, 0, 5); drive(0, 1, 0); drive(1, 0, 6); drive(1, 0, 7); drive(0, 0, 0);
    check("sync_alone_npairs", d_i.size(), 1);
    chk_pair("sync_alone", 0, 7, 6);

    clear_logs();
    drive(1, 0, 5); drive(1, 1, 9);
    check("sync_valid_nopulse", o_v, 0);
    drive(1, 0, 11); drive(0, 0, 0);
    check("sync_valid_npairs", d_i.size(), 1);
    chk_pair("sync_valid", 0, 11, 9);

    drive(1, 0, 77);
    #2 rst = 1'b1;
    #1;
    check("arst_inph", o_i, 0);
    check("arst_inph_dly", o_id, 0);
    check("arst_quad", o_q, 0);
    check("arst_quad_dly", o_qd, 0);
    check("arst_valid", o_v, 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    drive(1, 0, 3); drive(1, 0, 4); drive(0, 0, 0);
    check("arst_npairs", d_i.size(), 1);
    chk_pair("arst", 0, 4, 3);

    clear_logs();
`ifdef DDC_HB_COMMUTATOR_GAP_MON_EN
    drive(1, 0, 1);
    repeat (3) drive(0, 0, 0);
    check("gap_err_before_limit", o_err, 0);
    drive(0, 0, 0);
    check("gap_err_at_limit", o_err, 1);
    drive(1, 0, 2); drive(1, 0, 3); drive(0, 0, 0);
    check("gap_npairs", d_i.size(), 1);
    chk_pair("gap", 0, 3, 2);
    check("gap_err_sticky", o_err, 1);
    drive(0, 1, 0);
    check("gap_err_cleared", o_err, 0);
`else
    drive(1, 0, 1);
    repeat (10) drive(0, 0, 0);
    drive(1, 0, 2); drive(0, 0, 0);
    check("nogap_npairs", d_i.size(), 1);
    chk_pair("nogap", 0, 2, 1);
    check("nogap_err", o_err, 0);
`endif

    pv = 55;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       pv = 15;
          1:       pv = 55;
          default: pv = 100;
        endcase
      end
      in_v = ($urandom_range(0, 99) < pv);
      in_s = ($urandom_range(0, 99) < 4);
      in_i = W'($urandom);
      in_q = W'($urandom);
      @(posedge clk); #1;
    end
    drive(0, 0, 0); drive(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
